// File: rtl/fdiv_iter_pkg.sv
// -----------------------------------------------------------------------------
// fdiv_iter_pkg
// Shared FPU definitions for the iterative divider. The multiplier can reuse
// them as well.
//   - IEEE-754 single field widths and bias
//   - fixed encodings (all-ones exponent, canonical quiet NaN)
//   - divider datapath widths
//   - FSM state type for fdiv_iter
//   - helper that returns the effective (denormal-aware) exponent after
//     mantissa normalisation
// No ports (package).
// -----------------------------------------------------------------------------
package fdiv_iter_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int SIG_W = MAN_W + 1;    // significand including the implicit bit

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

    // Divider datapath widths
    localparam int Q_W   = 26;           // quotient bits: 1 integer + 25 fraction
    localparam int REM_W = 25;           // partial remainder
    localparam int LZ_W  = 5;            // leading-zero count of a 24-bit significand
    localparam int E_W   = 10;           // signed working exponent

    localparam logic signed [E_W-1:0] BIAS_E = 10'(BIAS);

    typedef enum logic [2:0] {
        IDLE,
        NORM_IN,
        DIV,
        NORM_OUT,
        DONE
    } fdiv_state_t;

    // Exponent field -> effective exponent minus the normalisation shift.
    // A zero field means the operand is denormal. Its effective exponent is 1.
    function automatic logic signed [E_W-1:0] eff_exp(input logic [EXP_W-1:0] e_fld,
                                                      input logic [LZ_W-1:0]  lz);
        logic [EXP_W-1:0] e_a;
        e_a = (e_fld == '0) ? 8'd1 : e_fld;
        return $signed({2'b00, e_a}) - $signed({5'b00000, lz});
    endfunction

endpackage

// File: rtl/fpu_lzc24.sv
// -----------------------------------------------------------------------------
// fpu_lzc24
// 24-bit leading-zero counter used to left-normalise significands.
// An all-zero input returns 24.
// Ports:
//   i_val  in  24  value to scan, starting at the MSB
//   o_cnt  out  5  number of leading zeros, from 0 to 24
// -----------------------------------------------------------------------------
module fpu_lzc24 (
    input  logic [23:0] i_val,
    output logic [4:0]  o_cnt
);

    always_comb begin
        // NOTE: o_cnt is given its value before the loop. Every path assigns it,
        //       so no latch is inferred.
        o_cnt = 5'd24;
        // The scan runs from the LSB upward, so the highest set bit is the last write.
        for (int i = 0; i < 24; i++) begin
            if (i_val[i]) begin
                o_cnt = 5'(23 - i);
            end
        end
    end

endmodule

// File: rtl/fdiv_iter.sv
// -----------------------------------------------------------------------------
// fdiv_iter
// Iterative IEEE-754 single-precision divider computing y = x1 / x2.
//   - The quotient comes from a restoring divider that retires BITS_PER_CYCLE
//     bits per cycle.
//   - The result is then normalised, with gradual underflow to denormals and
//     overflow to infinity.
//   - It is held until the consumer accepts it.
//   - Exponent 255 on input gets no special handling.
// Compile-time option:
//   FDIV_ROUND_EN defined   -> round to nearest even, applied after the
//                              underflow shift
//   FDIV_ROUND_EN undefined -> truncate
// Parameter:
//   BITS_PER_CYCLE  quotient bits per DIV cycle; legal values are 1 and 2
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   operand pair valid
//   in_ready   out  1   divider idle and able to accept operands
//   x1         in  32   dividend
//   x2         in  32   divisor
//   out_valid  out  1   result valid; held until out_ready
//   out_ready  in   1   consumer accepts the result
//   y          out 32   quotient
//   ovf        out  1   exponent overflowed; y is signed infinity
//   dz         out  1   divisor was zero
// -----------------------------------------------------------------------------
module fdiv_iter
    import fdiv_iter_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        ovf,
    output logic        dz
);

    localparam int               DIV_CYCLES = (Q_W + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    localparam logic [LZ_W-1:0]  CNT_LAST   = LZ_W'(DIV_CYCLES - 1);

    // ---------------------------------------------------------------- state
    fdiv_state_t r_state, w_next;

    logic [30:0]           r_x1, r_x2;      // magnitudes only; the sign lives in r_ss
    logic                  r_ss;
    logic [REM_W-1:0]      r_rem;
    logic [SIG_W-1:0]      r_div;
    logic [Q_W-1:0]        r_q;
    logic signed [E_W-1:0] r_exp;
    logic [LZ_W-1:0]       r_cnt;
    logic                  r_special;       // result was settled in NORM_IN
    logic [31:0]           r_y;
    logic                  r_ovf, r_dz;

    // ------------------------------------------------------------- NORM_IN
    logic [SIG_W-1:0]      w_m1, w_m2, w_m1n, w_m2n;
    logic [LZ_W-1:0]       w_lz1, w_lz2;
    logic signed [E_W-1:0] w_exp_in;
    logic                  w_x1_zero, w_x2_zero, w_special;
    logic [31:0]           w_sp_y;

    assign w_m1 = {r_x1[30:23] != '0, r_x1[22:0]};
    assign w_m2 = {r_x2[30:23] != '0, r_x2[22:0]};

    fpu_lzc24 u_lzc1 (.i_val(w_m1), .o_cnt(w_lz1));
    fpu_lzc24 u_lzc2 (.i_val(w_m2), .o_cnt(w_lz2));

    assign w_m1n    = w_m1 << w_lz1;
    assign w_m2n    = w_m2 << w_lz2;
    assign w_exp_in = eff_exp(r_x1[30:23], w_lz1) - eff_exp(r_x2[30:23], w_lz2) + BIAS_E;

    assign w_x1_zero = (r_x1 == '0);
    assign w_x2_zero = (r_x2 == '0);
    assign w_special = w_x1_zero | w_x2_zero;

    always_comb begin
        w_sp_y = {r_ss, 31'b0};
        if (w_x2_zero) begin
            w_sp_y = w_x1_zero ? QNAN : {r_ss, EXP_MAX, 23'h0};
        end
    end

    // ----------------------------------------------------------------- DIV
    // One restoring step per retired bit:
    //   - compare, conditionally subtract, then shift.
    //   - After a subtraction the remainder is below the divisor (< 2^24), so
    //     the shift always fits in 25 bits.
    logic [REM_W-1:0]          w_rem_nxt;
    logic [BITS_PER_CYCLE-1:0] w_qbits;

    always_comb begin
        w_rem_nxt = r_rem;
        w_qbits   = '0;
        for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
            if (w_rem_nxt >= {1'b0, r_div}) begin
                w_qbits[i] = 1'b1;
                w_rem_nxt  = w_rem_nxt - {1'b0, r_div};
            end
            w_rem_nxt = w_rem_nxt << 1;
        end
    end

    // ------------------------------------------------------------ NORM_OUT
    // The quotient lies in (0.5, 2). The MSB of w_qn is the implicit 1 and is dropped.
    logic [Q_W-2:0]        w_qn;
    logic signed [E_W-1:0] w_e, w_sh;
    logic [MAN_W-1:0]      w_mant0, w_mant;
    logic                  w_g0, w_st0, w_g, w_st;
    logic [SIG_W:0]        w_field, w_shf;
    logic                  w_lost;
    logic [EXP_W-1:0]      w_exp_f;
    logic                  w_inf, w_zero;
    logic [30:0]           w_mag, w_mag_r;
    logic [31:0]           w_res_y;
    logic                  w_res_ovf;

    assign w_qn    = r_q[Q_W-1] ? r_q[Q_W-2:0] : {r_q[Q_W-3:0], 1'b0};
    assign w_e     = r_q[Q_W-1] ? r_exp : r_exp - 10'sd1;
    assign w_mant0 = w_qn[Q_W-2:2];
    assign w_g0    = w_qn[1];
    assign w_st0   = w_qn[0] | (|r_rem);

    // Denormalising shift of {1, mantissa, guard}. Bits that drop below guard fold into sticky.
    assign w_sh    = 10'sd1 - w_e;
    assign w_field = {1'b1, w_mant0, w_g0};
    assign w_shf   = w_field >> w_sh[4:0];
    assign w_lost  = |(w_field & ~({(SIG_W+1){1'b1}} << w_sh[4:0]));

    always_comb begin
        w_exp_f = w_e[EXP_W-1:0];
        w_mant  = w_mant0;
        w_g     = w_g0;
        w_st    = w_st0;
        w_inf   = 1'b0;
        w_zero  = 1'b0;
        if (w_e >= 10'sd255) begin
            w_inf = 1'b1;
        end else if (w_e <= 10'sd0) begin
            if (w_sh > 10'sd24) begin
                w_zero = 1'b1;
            end else begin
                w_exp_f = '0;
                w_mant  = w_shf[SIG_W-1:1];
                w_g     = w_shf[0];
                w_st    = w_st0 | w_lost;
            end
        end
    end

    assign w_mag = {w_exp_f, w_mant};

`ifdef FDIV_ROUND_EN
    // The carry out of the mantissa runs straight into the exponent field.
    // This promotes a denormal to normal, or a maximal normal to infinity.
    logic w_rnd;
    logic w_unused_rnd;
    assign w_rnd        = w_g & (w_st | w_mant[0]);
    assign w_mag_r      = w_mag + {30'b0, w_rnd};
    assign w_unused_rnd = w_shf[SIG_W];
`else
    logic w_unused_rnd;
    assign w_mag_r      = w_mag;
    assign w_unused_rnd = w_g ^ w_st ^ w_shf[SIG_W];
`endif

    always_comb begin
        w_res_y   = {r_ss, w_mag_r};
        w_res_ovf = (w_mag_r[30:23] == EXP_MAX);
        if (w_inf) begin
            w_res_y   = {r_ss, EXP_MAX, 23'h0};
            w_res_ovf = 1'b1;
        end else if (w_zero) begin
            w_res_y   = {r_ss, 31'b0};
            w_res_ovf = 1'b0;
        end
    end

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        // NOTE: every sequential block uses non-blocking (<=) assignments.
        //       Each flop then samples pre-edge values. The always_comb
        //       blocks use blocking (=).
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Special results bypass DIV but still pass through NORM_OUT.
    // That keeps the zero and divide-by-zero latency at two cycles.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = NORM_IN;
            end
            NORM_IN:  w_next = w_special ? NORM_OUT : DIV;
            DIV:      if (r_cnt == '0) w_next = NORM_OUT;
            NORM_OUT: w_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default:  w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    // NOTE: these registers have no reset. Each one is written before it is
    //       read in every operation. Only the FSM state and the visible
    //       outputs need a defined reset value.
    always_ff @(posedge clk) begin
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    r_x1 <= x1[30:0];
                    r_x2 <= x2[30:0];
                    r_ss <= x1[31] ^ x2[31];
                end
            end
            NORM_IN: begin
                r_rem     <= {1'b0, w_m1n};
                r_div     <= w_m2n;
                r_exp     <= w_exp_in;
                r_q       <= '0;
                r_cnt     <= CNT_LAST;
                r_special <= w_special;
            end
            DIV: begin
                r_rem <= w_rem_nxt;
                r_q   <= {r_q[Q_W-1-BITS_PER_CYCLE:0], w_qbits};
                r_cnt <= r_cnt - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y   <= '0;
            r_ovf <= 1'b0;
            r_dz  <= 1'b0;
        end else if (r_state == NORM_IN && w_special) begin
            r_y   <= w_sp_y;
            r_ovf <= 1'b0;
            r_dz  <= w_x2_zero;
        end else if (r_state == NORM_OUT && !r_special) begin
            r_y   <= w_res_y;
            r_ovf <= w_res_ovf;
            r_dz  <= 1'b0;
        end
    end

    assign y   = r_y;
    assign ovf = r_ovf;
    assign dz  = r_dz;

endmodule
